cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Collects per-functional-unit result broadcasts (`cdb_t`) from the execute stage's add, mul, div and br units and serialises them onto one registered common data bus. The bus feeds the ROB, physical register file and reservation-station wakeup. Each source has a small result FIFO, and sources are served round-robin. Per-source `stall` backpressure lets the issue logic hold a unit whose results cannot yet be accepted.

## Interface
- `NUM_SRC`, default 4: number of result sources; index 0=add, 1=mul, 2=div, 3=br.
- `FIFO_DEPTH`, default 2: entries per source FIFO; must be a power of two, ≥2.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `flush` input, 1 bit: synchronous flush of all buffered results (mispredict recovery).
- `cdb_in` input, `cdb_t [NUM_SRC]`: source results; an entry is presented when `.valid`=1.
- `stall` output, `[NUM_SRC]`: source i must not present a result this cycle.
- `cdb_out` output, `cdb_t`: registered broadcast; fields are meaningful only when `.valid`=1.
- `grant_src` output, `[$clog2(NUM_SRC)]`: source index of the current `cdb_out`.
- `overflow` output, 1 bit: sticky error; set when a result is presented to a full FIFO.

## Operation
- **Push.** A FIFO i push occurs when `cdb_in[i].valid` && !`flush` && (!full[i] || pop[i]). The whole `cdb_t` is stored.
- **Arbitration.** Each cycle, among non-empty FIFOs, grant the first index at or after `rr_ptr`, wrapping modulo `NUM_SRC`.
  - The granted FIFO pops its head, and that head loads `cdb_out`.
  - `rr_ptr` becomes (granted+1) mod `NUM_SRC`.
  - If no FIFO is non-empty: `cdb_out.valid` ← 0, other `cdb_out` fields hold, `rr_ptr` holds.
- **Stall.** `stall[i]` = full[i] && !pop[i]. This is combinational, so a full FIFO popped this cycle accepts a push in the same cycle. Occupancy stays at `FIFO_DEPTH`.
- **Overflow.** Valid input while `stall[i]`=1: the input is dropped, `overflow` is set and stays set until reset.
- **Flush.** On the next edge:
  - All FIFOs are emptied and `cdb_out.valid` ← 0.
  - Inputs presented in the flush cycle are dropped without setting `overflow`.
  - `rr_ptr` is unchanged.
  - `stall` is forced to 0 during the flush cycle.
- **Pointer wrap.** FIFO read/write pointers carry one extra bit. full = (MSBs differ && low bits equal); empty = pointers equal.
- **Reset.** On `rst_n`=0, asynchronously:
  - all FIFOs empty, `rr_ptr`=0;
  - `cdb_out` all fields 0, `grant_src`=0, `overflow`=0;
  - `stall` reads 0.
  - Reset asserted mid-operation discards all buffered results, with no partial broadcast.

## Timing
- **Latency.** A result presented in cycle t, uncontended, appears on `cdb_out` in cycle t+2: enqueued at edge t, arbitrated in cycle t+1, registered at edge t+1.
- **Throughput.** One broadcast per cycle. `cdb_out.valid` is a one-cycle pulse per result, so back-to-back results give consecutive valid cycles.
- **Ordering.** Per-source order is preserved. Across sources, order is round-robin only.
- **Simultaneous events.**
  - A push and pop on the same FIFO in one cycle leaves occupancy unchanged.
  - `flush` takes priority over push and pop.
  - `rst_n` takes priority over everything.

## Structure
- **`rv32i_types`.** `cdb_t` already lives there. Add:
  - `CDB_NUM_SRC` = 4;
  - enum `cdb_src_t` {SRC_ADD, SRC_MUL, SRC_DIV, SRC_BR}.
- **`cdb_fifo` sub-module.** One instance per source, parameterised by `FIFO_DEPTH`.
  - Ports: `clk`, `rst_n`, `flush`, `push`, `din`, `pop`, `dout`, `full`, `empty`.
- **Top level.** Holds the round-robin arbiter, `rr_ptr`, the `cdb_out`/`grant_src` registers and `overflow`.

## Test plan
- **Single result.** Add result {rob_idx=5, pd_s=12, rd_s=3, rd_v=32'h1234} in cycle 0 → `cdb_out` carries exactly those fields with `grant_src`=0 in cycle 2 only.
- **Round-robin.** All four sources valid in cycle 0, `rr_ptr`=0 → `cdb_out` from add, mul, div, br in cycles 2, 3, 4, 5; `rr_ptr`=0 afterwards.
- **Backpressure.** Mul valid 4 consecutive cycles while add and div are also continuously valid (mul gets every third grant).
  - `stall[1]` rises once mul occupancy reaches 2 in a non-granted cycle.
  - No mul result is lost, and mul results arrive in issue order.
- **Overflow.** Drive `cdb_in[2].valid` while `stall[2]`=1 → `overflow`=1 from the next cycle on; that result never appears on `cdb_out`.
- **Flush.** Assert `flush` with 3 results buffered → `cdb_out.valid`=0 from the next cycle, with no further broadcasts until new inputs arrive.
- **Async reset.** Drop `rst_n` mid-cycle with all FIFOs full → `cdb_out`=0, `stall`=0 and `overflow`=0 immediately, without waiting for a clock edge. After release, a new add result appears 2 cycles later.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I core types: common data bus record, source ids and arbiter helpers.
package rv32i_types;

   typedef struct packed {
      logic        valid;
      logic [4:0]  rob_idx;
      logic [5:0]  pd_s;
      logic [4:0]  rd_s;
      logic [31:0] rd_v;
   } cdb_t;

   localparam int CDB_NUM_SRC = 4;

   typedef enum logic [1:0] {SRC_ADD, SRC_MUL, SRC_DIV, SRC_BR} cdb_src_t;

   // Single-step modulo: callers only ever exceed n by less than n.
   function automatic int rr_wrap(input int i, input int n);
      return (i >= n) ? i - n : i;
   endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Bus bundle between the execute-stage result sources and the CDB arbiter.
interface cdb_arbiter_if import rv32i_types::*; #(parameter int NUM_SRC = CDB_NUM_SRC);

   localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   logic                 flush;
   cdb_t [NUM_SRC-1:0]   cdb_in;
   logic [NUM_SRC-1:0]   stall;
   cdb_t                 cdb_out;
   logic [SW-1:0]        grant_src;
   logic                 overflow;

   modport master (
      output flush, cdb_in,
      input  stall, cdb_out, grant_src, overflow
   );

   modport slave (
      input  flush, cdb_in,
      output stall, cdb_out, grant_src, overflow
   );

endinterface

// File: rtl/cdb_fifo.sv
// Per-source result FIFO; pointers carry one wrap bit to separate full from empty.
module cdb_fifo import rv32i_types::*; #(
   parameter int FIFO_DEPTH = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic flush,
   input  logic push,
   input  cdb_t din,
   input  logic pop,
   output cdb_t dout,
   output logic full,
   output logic empty
);

   localparam int AW = $clog2(FIFO_DEPTH);

   cdb_t        mem [FIFO_DEPTH];
   logic [AW:0] wptr;
   logic [AW:0] rptr;

   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign empty = (wptr == rptr);
   assign dout  = mem[rptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
      end else if (flush) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + (AW+1)'(1);
         if (pop)  rptr <= rptr + (AW+1)'(1);
      end
   end

   // Storage needs no reset: empty pointers hide stale entries.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin serialiser of per-unit results onto one registered common data bus.
module cdb_arbiter import rv32i_types::*; #(
   parameter int NUM_SRC    = CDB_NUM_SRC,
   parameter int FIFO_DEPTH = 2
) (
   input logic          clk,
   input logic          rst_n,
   cdb_arbiter_if.slave bus
);

   localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   logic [NUM_SRC-1:0] vld_in;
   logic [NUM_SRC-1:0] push;
   logic [NUM_SRC-1:0] pop;
   logic [NUM_SRC-1:0] full;
   logic [NUM_SRC-1:0] empty;
   logic [NUM_SRC-1:0] stall;
   cdb_t [NUM_SRC-1:0] head;

   logic [SW-1:0] rr_ptr;
   logic [SW-1:0] gnt;
   logic          any;

   cdb_t          cdb_q;
   logic [SW-1:0] grant_q;
   logic          ovf_q;

   generate
      for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
         assign vld_in[i] = bus.cdb_in[i].valid;
         // Flush outranks both ends of the FIFO, and also releases backpressure.
         assign pop[i]    = any && (gnt == SW'(i)) && !bus.flush;
         assign push[i]   = vld_in[i] && !bus.flush && (!full[i] || pop[i]);
         assign stall[i]  = full[i] && !pop[i] && !bus.flush;

         cdb_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .flush (bus.flush),
            .push  (push[i]),
            .din   (bus.cdb_in[i]),
            .pop   (pop[i]),
            .dout  (head[i]),
            .full  (full[i]),
            .empty (empty[i])
         );
      end
   endgenerate

   // First non-empty source at or after rr_ptr, wrapping.
   always_comb begin
      logic [SW-1:0] idx;
      any = 1'b0;
      gnt = '0;
      idx = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         idx = SW'(rr_wrap(int'(rr_ptr) + k, NUM_SRC));
         if (!any && !empty[idx]) begin
            any = 1'b1;
            gnt = idx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cdb_q   <= '0;
         grant_q <= '0;
         rr_ptr  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         if (|(vld_in & stall)) ovf_q <= 1'b1;
         if (bus.flush) begin
            cdb_q.valid <= 1'b0;
         end else if (any) begin
            cdb_q       <= head[gnt];
            cdb_q.valid <= 1'b1;
            grant_q     <= gnt;
            rr_ptr      <= SW'(rr_wrap(int'(gnt) + 1, NUM_SRC));
         end else begin
            cdb_q.valid <= 1'b0;
         end
      end
   end

   assign bus.stall     = stall;
   assign bus.cdb_out   = cdb_q;
   assign bus.grant_src = grant_q;
   assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: vector table plus hand sequences for multi-cycle cases.
module tb_cdb_arbiter;
   import rv32i_types::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   cdb_arbiter_if #(.NUM_SRC(4)) bus();

   cdb_arbiter #(.NUM_SRC(4), .FIFO_DEPTH(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [3:0] vmask;
      logic [3:0] exp_stall;
      logic       exp_v;
      logic [1:0] exp_g;
      logic [4:0] exp_rob;
   } vec_t;

   vec_t tbl [14];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic cdb_t mk(input logic [4:0] rob, input logic [5:0] pd,
                               input logic [4:0] rd, input logic [31:0] v);
      cdb_t c;
      c.valid   = 1'b1;
      c.rob_idx = rob;
      c.pd_s    = pd;
      c.rd_s    = rd;
      c.rd_v    = v;
      return c;
   endfunction

   task automatic idle();
      bus.flush = 1'b0;
      for (int i = 0; i < 4; i++) bus.cdb_in[i] = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running, expected $finish");
      $fatal(1);
   end

   initial begin
      int add_sent, add_rx, mul_sent, mul_rx, div_sent, div_rx;
      bit saw_stall, seen_drop, dropped;
      int drop_rob;
      cdb_t single;

      // rob = r*4+i (5-bit), pd = source; rr pointer starts at 0.
      tbl[0]  = '{4'hF, 4'h0, 1'b0, 2'd0, 5'd0};
      tbl[1]  = '{4'h0, 4'h0, 1'b1, 2'd0, 5'd0};
      tbl[2]  = '{4'h0, 4'h0, 1'b1, 2'd1, 5'd1};
      tbl[3]  = '{4'h0, 4'h0, 1'b1, 2'd2, 5'd2};
      tbl[4]  = '{4'h0, 4'h0, 1'b1, 2'd3, 5'd3};
      tbl[5]  = '{4'h1, 4'h0, 1'b0, 2'd0, 5'd0};
      tbl[6]  = '{4'h0, 4'h0, 1'b1, 2'd0, 5'd20};
      tbl[7]  = '{4'h0, 4'h0, 1'b0, 2'd0, 5'd0};
      tbl[8]  = '{4'h3, 4'h0, 1'b0, 2'd0, 5'd0};
      tbl[9]  = '{4'h3, 4'h0, 1'b1, 2'd1, 5'd1};
      tbl[10] = '{4'h0, 4'h0, 1'b1, 2'd0, 5'd0};
      tbl[11] = '{4'h0, 4'h0, 1'b1, 2'd1, 5'd5};
      tbl[12] = '{4'h0, 4'h0, 1'b1, 2'd0, 5'd4};
      tbl[13] = '{4'h0, 4'h0, 1'b0, 2'd0, 5'd0};

      idle();
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset cdb_out",   bus.cdb_out,   '0);
      chk("reset grant_src", bus.grant_src, 0);
      chk("reset overflow",  bus.overflow,  0);
      chk("reset stall",     bus.stall,     0);
      rst_n = 1'b1;

      for (int r = 0; r < 14; r++) begin
         for (int i = 0; i < 4; i++)
            bus.cdb_in[i] = tbl[r].vmask[i] ?
               mk(5'(r*4+i), 6'(i), 5'(r), 32'hA000_0000 + 32'(r*16+i)) : '0;
         #1;
         chk($sformatf("tbl%0d stall", r), bus.stall, tbl[r].exp_stall);
         tick();
         chk($sformatf("tbl%0d valid", r), bus.cdb_out.valid, tbl[r].exp_v);
         if (tbl[r].exp_v) begin
            chk($sformatf("tbl%0d grant", r), bus.grant_src, tbl[r].exp_g);
            chk($sformatf("tbl%0d rob", r), bus.cdb_out.rob_idx, tbl[r].exp_rob);
            chk($sformatf("tbl%0d pd", r), bus.cdb_out.pd_s, 6'(tbl[r].exp_g));
         end
      end
      idle();

      // Single add result: visible two edges later, for exactly one cycle.
      single = mk(5'd5, 6'd12, 5'd3, 32'h1234);
      bus.cdb_in[0] = single;
      tick();
      idle();
      chk("single c1 valid", bus.cdb_out.valid, 0);
      tick();
      chk("single c2 cdb_out", bus.cdb_out, single);
      chk("single c2 grant", bus.grant_src, 0);
      tick();
      chk("single c3 valid", bus.cdb_out.valid, 0);

      // Backpressure: add/div/mul compete; sources hold while stalled.
      add_sent = 0; add_rx = 0; mul_sent = 0; mul_rx = 0; div_sent = 0; div_rx = 0;
      saw_stall = 0;
      for (int c = 0; c < 30; c++) begin
         idle();
         if (bus.stall[1]) saw_stall = 1;
         if (c < 12 && !bus.stall[0]) begin
            bus.cdb_in[0] = mk(5'(add_sent), 6'd0, 5'd0, 32'(add_sent)); add_sent++;
         end
         if (mul_sent < 4 && !bus.stall[1]) begin
            bus.cdb_in[1] = mk(5'(mul_sent), 6'd1, 5'd1, 32'(mul_sent)); mul_sent++;
         end
         if (c < 12 && !bus.stall[2]) begin
            bus.cdb_in[2] = mk(5'(div_sent), 6'd2, 5'd2, 32'(div_sent)); div_sent++;
         end
         tick();
         if (bus.cdb_out.valid) begin
            case (bus.grant_src)
               2'd0: begin chk("bp add order", bus.cdb_out.rob_idx, 5'(add_rx)); add_rx++; end
               2'd1: begin chk("bp mul order", bus.cdb_out.rob_idx, 5'(mul_rx)); mul_rx++; end
               2'd2: begin chk("bp div order", bus.cdb_out.rob_idx, 5'(div_rx)); div_rx++; end
               default: chk("bp unexpected br grant", bus.grant_src, 0);
            endcase
         end
      end
      idle();
      chk("bp mul stall seen", saw_stall, 1);
      chk("bp mul count", mul_rx, 4);
      chk("bp add count", add_rx, add_sent);
      chk("bp div count", div_rx, div_sent);
      chk("bp no overflow", bus.overflow, 0);

      // Flush with results buffered and full FIFOs presented to.
      for (int i = 0; i < 3; i++) bus.cdb_in[i] = mk(5'(20+i), 6'(i), 5'd0, 32'd0);
      tick();
      for (int i = 0; i < 3; i++) bus.cdb_in[i] = mk(5'(23+i), 6'(i), 5'd0, 32'd0);
      tick();
      bus.flush = 1'b1;
      for (int i = 0; i < 4; i++) bus.cdb_in[i] = mk(5'(26+i), 6'(i), 5'd0, 32'd0);
      #1;
      chk("flush stall forced 0", bus.stall, 0);
      tick();
      idle();
      chk("flush valid", bus.cdb_out.valid, 0);
      chk("flush no overflow", bus.overflow, 0);
      for (int c = 0; c < 4; c++) begin
         tick();
         chk($sformatf("post-flush idle%0d valid", c), bus.cdb_out.valid, 0);
      end
      bus.cdb_in[0] = mk(5'd30, 6'd0, 5'd0, 32'd0);
      tick();
      idle();
      tick();
      chk("post-flush new valid", bus.cdb_out.valid, 1);
      chk("post-flush new rob", bus.cdb_out.rob_idx, 30);
      chk("post-flush new grant", bus.grant_src, 0);
      tick();

      // Overflow: div presents every cycle regardless of stall.
      add_sent = 0; mul_sent = 0;
      dropped = 0; seen_drop = 0; drop_rob = -1;
      for (int c = 0; c < 20; c++) begin
         idle();
         if (c < 8) begin
            if (!bus.stall[0]) begin bus.cdb_in[0] = mk(5'(add_sent), 6'd0, 5'd0, 32'd0); add_sent++; end
            if (!bus.stall[1]) begin bus.cdb_in[1] = mk(5'(mul_sent), 6'd1, 5'd0, 32'd0); mul_sent++; end
            if (!dropped) begin
               bus.cdb_in[2] = mk(5'(8+c), 6'd2, 5'd0, 32'd0);
               if (bus.stall[2]) begin
                  dropped = 1;
                  drop_rob = 8 + c;
                  chk("ovf clear before drop", bus.overflow, 0);
               end
            end
         end
         tick();
         if (dropped && drop_rob == 8 + c) chk("ovf set next cycle", bus.overflow, 1);
         if (bus.cdb_out.valid && bus.grant_src == 2'd2 && int'(bus.cdb_out.rob_idx) == drop_rob)
            seen_drop = 1;
      end
      idle();
      chk("ovf drop happened", dropped, 1);
      chk("ovf dropped never broadcast", seen_drop, 0);
      chk("ovf sticky", bus.overflow, 1);

      // Async reset mid-cycle with FIFOs full.
      for (int c = 0; c < 3; c++) begin
         for (int i = 0; i < 4; i++) bus.cdb_in[i] = mk(5'(c*4+i), 6'(i), 5'd0, 32'd0);
         tick();
      end
      #2;
      chk("pre-reset valid", bus.cdb_out.valid, 1);
      rst_n = 1'b0;
      #1;
      chk("async reset cdb_out", bus.cdb_out, '0);
      chk("async reset stall", bus.stall, 0);
      chk("async reset overflow", bus.overflow, 0);
      chk("async reset grant", bus.grant_src, 0);
      idle();
      tick();
      rst_n = 1'b1;
      bus.cdb_in[0] = mk(5'd7, 6'd0, 5'd0, 32'h77);
      tick();
      idle();
      chk("post-reset c1 valid", bus.cdb_out.valid, 0);
      tick();
      chk("post-reset c2 valid", bus.cdb_out.valid, 1);
      chk("post-reset c2 rob", bus.cdb_out.rob_idx, 7);
      chk("post-reset c2 grant", bus.grant_src, 0);
      tick();
      chk("post-reset c3 valid", bus.cdb_out.valid, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
